// File: rtl/ws2812_pkg.sv
// ws2812_pkg -- shared types and constants for the WS2812 transmitter.
//   state_t       : transmitter FSM states (IDLE, SEND, LATCH)
//   DEF_*         : default timing for a 50 MHz clock
//   PIXEL_W       : bits per LED word (green, red, blue bytes)
//   COLOR_ORDER   : byte order on the wire (GRB, MSB first)
//   pack_pixel()  : builds the on-wire word from the three colour bytes
package ws2812_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  // 50 MHz clock: 400 ns / 800 ns high, 1.26 us bit, 300 us latch gap.
  localparam int DEF_MAX_POS = 109;
  localparam int DEF_T0H     = 20;
  localparam int DEF_T1H     = 40;
  localparam int DEF_T_BIT   = 63;
  localparam int DEF_T_RESET = 15000;

  localparam int PIXEL_W = 24;

  typedef enum logic [0:0] {
    ORDER_GRB = 1'b0
  } color_order_t;

  localparam color_order_t COLOR_ORDER = ORDER_GRB;

  // WS2812 expects green first, then red, then blue.
  function automatic logic [PIXEL_W-1:0] pack_pixel(input logic [7:0] green,
                                                     input logic [7:0] red,
                                                     input logic [7:0] blue);
    return {green, red, blue};
  endfunction

endpackage

// File: rtl/ws2812_tx_if.sv
// ws2812_tx_if -- intensity bus between the screen manager and ws2812_tx.
//   start             : frame request (master -> slave)
//   led_num           : LED index whose colours are requested (slave -> master)
//   i_*_intensity     : colour bytes for led_num, combinational (master -> slave)
//   busy              : frame in progress (slave -> master)
//   frame_done        : one-cycle pulse on the last latch cycle (slave -> master)
// The transmitter uses the slave modport; the screen manager the master one.
interface ws2812_tx_if #(
  parameter int MAX_POS = ws2812_pkg::DEF_MAX_POS
) ();
  localparam int LED_W = $clog2(MAX_POS);

  logic             start;
  logic [LED_W-1:0] led_num;
  logic [7:0]       i_green_intensity;
  logic [7:0]       i_red_intensity;
  logic [7:0]       i_blue_intensity;
  logic             busy;
  logic             frame_done;

  modport master (
    output start,
    output i_green_intensity,
    output i_red_intensity,
    output i_blue_intensity,
    input  led_num,
    input  busy,
    input  frame_done
  );

  modport slave (
    input  start,
    input  i_green_intensity,
    input  i_red_intensity,
    input  i_blue_intensity,
    output led_num,
    output busy,
    output frame_done
  );
endinterface

// File: rtl/ws2812_bit_encoder.sv
// ws2812_bit_encoder -- NRZ pulse-width encoder for one WS2812 bit at a time.
//   clk, rst  : clock, synchronous active-high reset
//   load      : start a new bit on this edge (bit counter restarts at 0)
//   bit_value : value of the bit being loaded
//   dout      : registered data line, high for T1H (1) or T0H (0) cycles
//   bit_end   : high on the last counter cycle (T_BIT-1) of the current bit
// If bit_end is not answered with load, the encoder goes quiet (dout low).
module ws2812_bit_encoder #(
  parameter int T0H   = ws2812_pkg::DEF_T0H,
  parameter int T1H   = ws2812_pkg::DEF_T1H,
  parameter int T_BIT = ws2812_pkg::DEF_T_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic bit_value,
  output logic dout,
  output logic bit_end
);
  localparam int CNT_W = $clog2(T_BIT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;
  logic             bit_q;
  logic             active_q;

  // Never evaluated on the last cycle of a bit, so it cannot exceed T_BIT-1.
  assign cnt_inc = cnt_q + CNT_W'(1);
  assign bit_end = active_q && (cnt_q == CNT_W'(T_BIT - 1));

  // dout is computed from the counter value it will be shown with, so the
  // line is registered yet exactly aligned with the counter.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register reading the
    // pre-edge values of the others, whatever the statement order.
    if (rst) begin
      // NOTE: all state is reset, not just control, so the data line is low
      // and the counter is at 0 from the first edge after reset.
      cnt_q    <= '0;
      bit_q    <= 1'b0;
      active_q <= 1'b0;
      dout     <= 1'b0;
    end else if (load) begin
      cnt_q    <= '0;
      bit_q    <= bit_value;
      active_q <= 1'b1;
      dout     <= 1'b1;  // both encodings start high since T0H > 0
    end else if (bit_end) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
      dout     <= 1'b0;
    end else if (active_q) begin
      cnt_q <= cnt_inc;
      dout  <= cnt_inc < (bit_q ? CNT_W'(T1H) : CNT_W'(T0H));
    end
  end

endmodule

// File: rtl/ws2812_tx.sv
// ws2812_tx -- WS2812 single-wire transmitter for an LED strip.
//   clk, rst : clock, synchronous active-high reset
//   bus      : ws2812_tx_if.slave (start, led_num, colour bytes, busy,
//              frame_done)
//   dout     : registered WS2812 data line
// Shifts MAX_POS pixels out GRB, MSB first, then holds the line low for
// T_RESET cycles. led_num always points one pixel ahead of the pixel on the
// wire, so the screens get a whole pixel time to settle each word.
// Build option: WS2812_AUTO_REFRESH_EN -- frames run back to back from the
// first cycle after reset and start is ignored.
module ws2812_tx
  import ws2812_pkg::*;
#(
  parameter int MAX_POS = DEF_MAX_POS,
  parameter int T0H     = DEF_T0H,
  parameter int T1H     = DEF_T1H,
  parameter int T_BIT   = DEF_T_BIT,
  parameter int T_RESET = DEF_T_RESET
) (
  input  logic clk,
  input  logic rst,
  ws2812_tx_if.slave bus,
  output logic dout
);
  localparam int LED_W = $clog2(MAX_POS);
  localparam int LAT_W = $clog2(T_RESET);
  localparam int IDX_W = $clog2(PIXEL_W);

  state_t               state_q, state_d;
  logic [PIXEL_W-2:0]   rest_q;     // bits still to send after the current one
  logic [IDX_W-1:0]     bit_idx_q;  // index of the bit on the wire, 23..0
  logic [LED_W-1:0]     led_q;
  logic                 last_q;     // pixel on the wire is LED MAX_POS-1
  logic [LAT_W-1:0]     latch_q;

  logic [PIXEL_W-1:0]   pixel_in;
  logic                 go;
  logic                 capture;
  logic                 shift;
  logic                 latch_last;
  logic                 enc_load;
  logic                 enc_bit;
  logic                 bit_end;

  assign pixel_in   = pack_pixel(bus.i_green_intensity, bus.i_red_intensity,
                                 bus.i_blue_intensity);
  assign latch_last = (latch_q == LAT_W'(T_RESET - 1));

`ifdef WS2812_AUTO_REFRESH_EN
  assign go = 1'b1;
`else
  assign go = bus.start;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output of this block gets a default before the case, so
    // no path leaves a signal unassigned and no latch is inferred.
    state_d = state_q;
    capture = 1'b0;
    shift   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (go) begin
          state_d = ST_SEND;
          capture = 1'b1;
        end
      end
      ST_SEND: begin
        if (bit_end) begin
          if (bit_idx_q != '0) shift = 1'b1;
          else if (!last_q)    capture = 1'b1;
          else                 state_d = ST_LATCH;
        end
      end
      ST_LATCH: begin
        if (latch_last) begin
`ifdef WS2812_AUTO_REFRESH_EN
          state_d = ST_SEND;
          capture = 1'b1;  // led_num has already wrapped to 0
`else
          state_d = ST_IDLE;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A capture or shift always restarts the encoder with the next MSB.
  assign enc_load = capture | shift;
  assign enc_bit  = capture ? pixel_in[PIXEL_W-1] : rest_q[PIXEL_W-2];

  always_ff @(posedge clk) begin
    if (rst) begin
      rest_q    <= '0;
      bit_idx_q <= '0;
      led_q     <= '0;
      last_q    <= 1'b0;
      latch_q   <= '0;
    end else begin
      if (capture) begin
        rest_q    <= pixel_in[PIXEL_W-2:0];
        bit_idx_q <= IDX_W'(PIXEL_W - 1);
        last_q    <= (led_q == LED_W'(MAX_POS - 1));
        led_q     <= (led_q == LED_W'(MAX_POS - 1)) ? '0 : led_q + LED_W'(1);
      end else if (shift) begin
        rest_q    <= {rest_q[PIXEL_W-3:0], 1'b0};
        bit_idx_q <= bit_idx_q - IDX_W'(1);
      end
      // Holds 0 outside LATCH, so it is ready the moment LATCH is entered.
      latch_q <= (state_q == ST_LATCH && !latch_last) ? latch_q + LAT_W'(1) : '0;
    end
  end

  ws2812_bit_encoder #(
    .T0H  (T0H),
    .T1H  (T1H),
    .T_BIT(T_BIT)
  ) u_encoder (
    .clk      (clk),
    .rst      (rst),
    .load     (enc_load),
    .bit_value(enc_bit),
    .dout     (dout),
    .bit_end  (bit_end)
  );

  assign bus.led_num    = led_q;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.frame_done = (state_q == ST_LATCH) && latch_last;

endmodule

// File: tb/tb_ws2812_tx.sv
// tb_ws2812_tx -- self-checking bench for ws2812_tx with a small strip.
// The reference model derives the expected line level, busy, frame_done and
// led_num for every cycle of a frame directly from the WS2812 timing rules;
// the dout stream is also decoded back into pixel words.
module tb_ws2812_tx;
  localparam int MAX_POS  = 3;
  localparam int T0H      = 2;
  localparam int T1H      = 4;
  localparam int T_BIT    = 6;
  localparam int T_RESET  = 10;
  localparam int LED_W    = $clog2(MAX_POS);
  localparam int PIX_CYC  = 24 * T_BIT;
  localparam int SEND_CYC = MAX_POS * PIX_CYC;
  localparam int FRAME    = SEND_CYC + T_RESET;

  typedef struct packed {
    logic             dout;
    logic             busy;
    logic             fd;
    logic [LED_W-1:0] led;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dout;

  logic [7:0] g_tab [MAX_POS];
  logic [7:0] r_tab [MAX_POS];
  logic [7:0] b_tab [MAX_POS];

  int vectors     = 0;
  int miscompares = 0;

  ws2812_tx_if #(.MAX_POS(MAX_POS)) bus ();

  ws2812_tx #(
    .MAX_POS(MAX_POS),
    .T0H    (T0H),
    .T1H    (T1H),
    .T_BIT  (T_BIT),
    .T_RESET(T_RESET)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .dout(dout)
  );

  always #5 clk = ~clk;

  // Screens: colour bytes follow led_num combinationally.
  always_comb begin
    bus.i_green_intensity = 8'h00;
    bus.i_red_intensity   = 8'h00;
    bus.i_blue_intensity  = 8'h00;
    if (int'(bus.led_num) < MAX_POS) begin
      bus.i_green_intensity = g_tab[bus.led_num];
      bus.i_red_intensity   = r_tab[bus.led_num];
      bus.i_blue_intensity  = b_tab[bus.led_num];
    end
  end

  function automatic obs_t observe();
    return {dout, bus.busy, bus.frame_done, bus.led_num};
  endfunction

  // Expected outputs t cycles after the frame's first busy cycle.
  function automatic obs_t model(input int t);
    obs_t        o;
    logic [23:0] w;
    int          p, b, ph;
    o = '0;
    o.busy = 1'b1;
    if (t < SEND_CYC) begin
      p  = t / PIX_CYC;
      b  = (t % PIX_CYC) / T_BIT;
      ph = t % T_BIT;
      w  = {g_tab[p], r_tab[p], b_tab[p]};
      o.dout = (ph < (w[23-b] ? T1H : T0H));
      o.led  = LED_W'((p + 1) % MAX_POS);
    end else begin
      o.fd = (t == FRAME - 1);
    end
    return o;
  endfunction

  task automatic fill_random();
    for (int k = 0; k < MAX_POS; k++) begin
      g_tab[k] = 8'($urandom);
      r_tab[k] = 8'($urandom);
      b_tab[k] = 8'($urandom);
    end
  endtask

  // Pulses start, follows one frame cycle by cycle, optionally pulses start
  // again at p1/p2 or asserts rst at rst_at, and decodes the words sent.
  task automatic run_frame(input string name, input int p1, input int p2,
                           input int rst_at);
    obs_t        obs, exp;
    logic [23:0] dec [MAX_POS];
    logic [23:0] want;
    int          highs;
    highs = 0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int t = 0; t < FRAME; t++) begin
      obs = observe();
      exp = model(t);
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL %s t=%0d got dout=%b busy=%b fd=%b led=%0d expected dout=%b busy=%b fd=%b led=%0d",
                 name, t, obs.dout, obs.busy, obs.fd, obs.led,
                 exp.dout, exp.busy, exp.fd, exp.led);
      end
      if (t < SEND_CYC) begin
        if (dout === 1'b1) highs++;
        if (t % T_BIT == T_BIT - 1) begin
          dec[t / PIX_CYC][23 - (t % PIX_CYC) / T_BIT] = (2 * highs > T0H + T1H);
          highs = 0;
        end
      end
      if (t == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        obs = observe();
        vectors++;
        if (obs !== obs_t'(0)) begin
          miscompares++;
          $display("FAIL %s_abort got dout=%b busy=%b fd=%b led=%0d expected all 0",
                   name, obs.dout, obs.busy, obs.fd, obs.led);
        end
        rst = 1'b0;
        @(negedge clk);
        return;
      end
      bus.start = (t == p1) || (t == p2);
      @(negedge clk);
    end
    bus.start = 1'b0;
    obs = observe();
    vectors++;
    if (obs.busy !== 1'b0 || obs.fd !== 1'b0 || obs.dout !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_end got busy=%b fd=%b dout=%b expected 0 0 0",
               name, obs.busy, obs.fd, obs.dout);
    end
    for (int k = 0; k < MAX_POS; k++) begin
      want = {g_tab[k], r_tab[k], b_tab[k]};
      vectors++;
      if (dec[k] !== want) begin
        miscompares++;
        $display("FAIL %s_word%0d got %06h expected %06h", name, k, dec[k], want);
      end
    end
  endtask

  task automatic test_reset();
    obs_t obs;
    rst = 1'b1;
    bus.start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      obs = observe();
      vectors++;
      if (obs !== obs_t'(0)) begin
        miscompares++;
        $display("FAIL reset_hold c=%0d got dout=%b busy=%b fd=%b led=%0d expected all 0",
                 c, obs.dout, obs.busy, obs.fd, obs.led);
      end
    end
    rst = 1'b0;
`ifndef WS2812_AUTO_REFRESH_EN
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      obs = observe();
      vectors++;
      if (obs !== obs_t'(0)) begin
        miscompares++;
        $display("FAIL reset_after c=%0d got dout=%b busy=%b fd=%b led=%0d expected all 0",
                 c, obs.dout, obs.busy, obs.fd, obs.led);
      end
    end
`endif
  endtask

  task automatic test_single_frame();
    for (int k = 0; k < MAX_POS; k++) begin
      g_tab[k] = 8'h80;
      r_tab[k] = 8'h00;
      b_tab[k] = 8'h00;
    end
    run_frame("single", -1, -1, -1);
  endtask

  task automatic test_prefetch();
    for (int k = 0; k < MAX_POS; k++) begin
      g_tab[k] = 8'(k + 1);
      r_tab[k] = 8'h05;
      b_tab[k] = 8'hA5;
    end
    run_frame("prefetch", -1, -1, -1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 4; n++) begin
      fill_random();
      run_frame("random", -1, -1, -1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  task automatic test_ignored_start();
    fill_random();
    run_frame("ign_start", 50, SEND_CYC + 3, -1);
    for (int c = 0; c < 5; c++) begin
      vectors++;
      if (bus.busy !== 1'b0) begin
        miscompares++;
        $display("FAIL ign_start_idle c=%0d got busy=%b expected 0", c, bus.busy);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_frame();
    fill_random();
    run_frame("midrst", -1, -1, PIX_CYC + 10 * T_BIT);
    fill_random();
    run_frame("after_rst", -1, -1, -1);
  endtask

  task automatic test_back_to_back();
    fill_random();
    run_frame("b2b_a", -1, -1, -1);
    fill_random();
    run_frame("b2b_b", -1, -1, -1);
  endtask

  task automatic test_auto_refresh();
    obs_t obs, exp;
    int   fd_seen;
    fd_seen = 0;
    @(negedge clk);  // idle cycle that launches the first frame
    for (int t = 0; t < 3 * FRAME; t++) begin
      obs = observe();
      exp = model(t % FRAME);
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL auto t=%0d got dout=%b busy=%b fd=%b led=%0d expected dout=%b busy=%b fd=%b led=%0d",
                 t, obs.dout, obs.busy, obs.fd, obs.led,
                 exp.dout, exp.busy, exp.fd, exp.led);
      end
      if (obs.fd === 1'b1) fd_seen++;
      @(negedge clk);
    end
    vectors++;
    if (fd_seen != 3) begin
      miscompares++;
      $display("FAIL auto_frames got %0d frame_done pulses expected 3", fd_seen);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    for (int k = 0; k < MAX_POS; k++) begin
      g_tab[k] = 8'h00;
      r_tab[k] = 8'h00;
      b_tab[k] = 8'h00;
    end
`ifdef WS2812_AUTO_REFRESH_EN
    fill_random();
    test_reset();
    test_auto_refresh();
`else
    test_reset();
    test_single_frame();
    test_prefetch();
    test_random();
    test_ignored_start();
    test_reset_mid_frame();
    test_back_to_back();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ws2812_tx.md
# ws2812_tx

Serial transmitter that turns the per-LED colour intensities produced by the screen manager into a WS2812 single-wire bitstream. It drives the LED index (`led_num`) to the screens, captures the returned green/red/blue bytes, and shifts them out GRB, MSB first, with NRZ pulse-width timing, followed by a latch (reset) gap. It sits between the screen manager's intensity bus and the strip's data pin.

## Interface
- `MAX_POS`, 109: LEDs in the strip. Indices run 0..MAX_POS-1.
- `T0H`, 20: high cycles for a 0 bit (400 ns at 50 MHz).
- `T1H`, 40: high cycles for a 1 bit (800 ns).
- `T_BIT`, 63: total cycles per bit (1.26 µs). Requires T_BIT > T1H > T0H > 0.
- `T_RESET`, 15000: low cycles of the latch gap (300 µs).

Ports:
- `clk`, in, 1: system clock. One clock domain.
- `rst`, in, 1: reset. Synchronous, active-high.
- `start`, in, 1: frame request. Sampled only in IDLE.
- `led_num`, out, $clog2(MAX_POS): index of the LED whose intensities are requested.
- `i_green_intensity`, in, 8: green byte for `led_num`. Combinational from the screens.
- `i_red_intensity`, in, 8: red byte for `led_num`.
- `i_blue_intensity`, in, 8: blue byte for `led_num`.
- `dout`, out, 1: WS2812 data line. Registered.
- `busy`, out, 1: high from frame start to the end of the latch gap.
- `frame_done`, out, 1: one-cycle pulse on the last LATCH cycle.

## Operation
- **States**
  - IDLE: `dout`=0, `busy`=0.
  - SEND: shifting pixels out.
  - LATCH: `dout`=0 for T_RESET cycles.
- **Reset values:** state IDLE, `dout`=0, `led_num`=0, `busy`=0, `frame_done`=0, all counters 0.
- **IDLE → SEND** when `start`=1.
  - On the same edge, capture the 24-bit word {green, red, blue} for `led_num`=0.
  - Set `led_num`=1 (prefetch), bit index 23, bit counter 0.
- **Bit encoding**
  - Bit counter runs 0..T_BIT-1.
  - `dout`=1 while counter < T1H for a 1 bit, or < T0H for a 0 bit. Otherwise 0.
- **Word boundary**
  - At the end of bit 0 of pixel n (n < MAX_POS-1), capture the next word from the intensity inputs on the same edge, with no gap.
  - On that edge, `led_num` increments.
  - `led_num` therefore always points one pixel ahead of the pixel being shifted.
  - The screens have a full pixel time (24·T_BIT cycles) to settle.
- **Last pixel**
  - When the word for index MAX_POS-1 is captured, `led_num` wraps to 0.
  - At the end of its bit 0, go to LATCH.
- **LATCH**
  - Counter runs 0..T_RESET-1.
  - On the last cycle, pulse `frame_done` and return to IDLE (or SEND, see Configuration).
- **`start` handling:** `start` in SEND or LATCH is ignored and not queued.
- **Reset mid-frame:** `rst` forces IDLE and `dout`=0 on the next edge. The partial frame is abandoned, and the following latch gap is the caller's responsibility.
- **Widths:**
  - Bit counter: $clog2(T_BIT) bits.
  - Latch counter: $clog2(T_RESET) bits.
  - No arithmetic exceeds these widths.

## Timing
- **Latency from `start`:** `dout` and `busy` rise one cycle after the cycle in which `start`=1 is sampled.
- **Frame length:** MAX_POS·24·T_BIT + T_RESET cycles of `busy`=1.
- **Bit period:** every bit spans exactly T_BIT cycles. Pixel and frame boundaries add no extra cycles.
- **End of frame:** `busy` falls on the cycle after `frame_done`. A `start` on that IDLE cycle begins a new frame.

## Configuration
- **`WS2812_AUTO_REFRESH_EN` defined:**
  - After LATCH, the next frame starts immediately (LATCH → SEND, LED 0 captured).
  - `start` is unused.
  - The first frame starts on the first cycle after reset deasserts.
  - `busy` stays 1 except in that reset/first cycle.
- **Undefined:** frames run only on `start` pulses, as described above.

## Structure
- **Package `ws2812_pkg`:**
  - State enum (IDLE, SEND, LATCH).
  - Default timing constants for a 50 MHz clock.
  - Pixel word width (24).
  - Colour byte order constant (GRB).
- **Sub-module `ws2812_bit_encoder`:**
  - Inputs: `load`, `bit_value`.
  - Owns the bit counter and `dout` generation.
  - Outputs `bit_end` on the last counter cycle.
  - The top level keeps the FSM, the shift register, `led_num`, and the latch counter.

## Test plan
All scenarios use MAX_POS=3, T0H=2, T1H=4, T_BIT=6, T_RESET=10.
- **Reset:** reset held for 3 cycles → `dout`=0, `busy`=0, `led_num`=0, `frame_done`=0 throughout and after release.
- **Single frame:** intensities G=8'h80, R=0, B=0 for all LEDs; one `start` pulse → first bit high 4 cycles / low 2, next 23 bits high 2 / low 4. `busy` high exactly 442 cycles, then `frame_done` pulses once.
- **Prefetch:** screens drive LED k with G=k+1, R=0x05, B=0xA5 → captured words are 0x0105A5, 0x0205A5, 0x0305A5 in order. `led_num` sequence is 0→1→2→0, each change coinciding with a word capture.
- **Ignored start:** `start` pulsed during SEND and again during LATCH → frame length unchanged, no second frame, IDLE after `frame_done`.
- **Reset mid-frame:** `rst` asserted at bit 10 of LED 1 → `dout`=0 and `busy`=0 on the next edge. A new `start` then produces a full, correct frame from LED 0.
- **Auto refresh:** with `WS2812_AUTO_REFRESH_EN` defined and `start` tied 0 → back-to-back frames, `frame_done` every 442 cycles, `dout` low during each 10-cycle latch gap.
